// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared UART types and defaults for the transmitter and receiver.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    // PARITY keeps its code point even in builds without parity support
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL         = 1'b1;
    localparam int   UART_DATA_BITS_DEFAULT  = 8;
    localparam int   UART_STOP_BITS_DEFAULT  = 1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_framer.sv
// +----------------------------------------------------------------------+
// | uart_tx_framer                                                       |
// | Baud-tick driven UART transmitter with a one-deep holding register.  |
// | Optional even parity bit when UART_TX_PARITY_EN is defined.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEFAULT,
    parameter int STOP_BITS = UART_STOP_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy
);

    localparam int                 c_CNT_W     = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT  = c_CNT_W'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          r_state;
    uart_state_e          w_state_nx;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_CNT_W-1:0]   w_bit_cnt_nx;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_nx;
    logic                 r_hold_full;
    logic                 w_hold_full_nx;
    logic                 r_ready;
    logic                 r_txd;
    logic                 w_txd_nx;
    logic                 w_load;
    logic                 w_accept;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_bit_cnt_nx  = r_bit_cnt;
        w_stop_cnt_nx = r_stop_cnt;
        w_txd_nx      = r_txd;
        w_load        = 1'b0;
        w_accept      = tx_valid && r_ready;

        if (baud_tick) begin
            case (r_state)
                IDLE: begin
                    if (r_hold_full) begin
                        w_load     = 1'b1;
                        w_state_nx = START;
                        w_txd_nx   = 1'b0;
                    end
                end
                START: begin
                    w_state_nx = DATA;
                    w_txd_nx   = r_shift[0];
                end
                DATA: begin
                    w_shift_nx   = r_shift >> 1;
                    w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = PARITY;
                        w_txd_nx   = r_parity;
`else
                        w_state_nx = STOP;
                        w_txd_nx   = UART_IDLE_LEVEL;
`endif
                    end else begin
                        w_txd_nx = r_shift[1];
                    end
                end
                PARITY: begin
                    w_state_nx = STOP;
                    w_txd_nx   = UART_IDLE_LEVEL;
                end
                STOP: begin
                    // A held byte chains straight into its start bit
                    if (r_stop_cnt == c_LAST_STOP) begin
                        if (r_hold_full) begin
                            w_load     = 1'b1;
                            w_state_nx = START;
                            w_txd_nx   = 1'b0;
                        end else begin
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_stop_cnt_nx = r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end

        if (w_load) begin
            w_shift_nx    = r_hold;
            w_bit_cnt_nx  = '0;
            w_stop_cnt_nx = 1'b0;
        end

        if (w_load) begin
            w_hold_full_nx = 1'b0;
        end else if (w_accept) begin
            w_hold_full_nx = 1'b1;
        end else begin
            w_hold_full_nx = r_hold_full;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_txd       <= UART_IDLE_LEVEL;
        end else begin
            if (w_accept) begin
                r_hold <= tx_data;
            end
            r_shift     <= w_shift_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_stop_cnt  <= w_stop_cnt_nx;
            r_hold_full <= w_hold_full_nx;
            r_ready     <= !w_hold_full_nx;
            r_txd       <= w_txd_nx;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^r_hold;
        end
    end
`endif

    assign tx_ready = r_ready;
    assign txd      = r_txd;
    assign tx_busy  = (r_state != IDLE) || r_hold_full;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_framer                                                    |
// | Self-checking bench: frame-level bit-queue model plus vector table.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_valid2 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, txd, tx_busy;
    logic       tx_ready2, txd2, tx_busy2;

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy)
    );

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .txd(txd2), .tx_busy(tx_busy2)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_acc = 0;

    // Reference: line bits still to be sent, one pending byte, line-active flag
    bit         bitq[$];
    bit         m_full = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_online = 1'b0;
    bit         m_txd = 1'b1;

    typedef struct {
        bit         tick;
        bit         valid;
        logic [7:0] data;
        bit         e_txd;
        bit         e_ready;
        bit         e_busy;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int nstop);
        bitq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bitq.push_back(d[i]);
        if (P == 1) bitq.push_back(^d);
        for (int i = 0; i < nstop; i++) bitq.push_back(1'b1);
    endtask

    task automatic model_edge(input bit t, input bit v, input logic [7:0] d, input bit r);
        bit ready_pre;
        ready_pre = !m_full;
        if (r) begin
            bitq.delete();
            m_full   = 1'b0;
            m_online = 1'b0;
            m_txd    = 1'b1;
        end else begin
            if (t) begin
                if (bitq.size() == 0 && m_full) begin
                    push_frame(m_data, 1);
                    m_full = 1'b0;
                end
                if (bitq.size() != 0) begin
                    m_txd    = bitq.pop_front();
                    m_online = 1'b1;
                end else begin
                    m_txd    = 1'b1;
                    m_online = 1'b0;
                end
            end
            if (v && ready_pre) begin
                m_full = 1'b1;
                m_data = d;
            end
        end
    endtask

    task automatic cycle(input bit t, input bit v, input logic [7:0] d, input bit r = 1'b0);
        baud_tick = t;
        tx_valid  = v;
        tx_data   = d;
        reset     = r;
        if (v && tx_ready === 1'b1) n_acc++;
        @(posedge clk);
        model_edge(t, v, d, r);
        #1;
        check("txd", txd, m_txd);
        check("tx_ready", tx_ready, !m_full);
        check("tx_busy", tx_busy, m_online || m_full);
    endtask

    task automatic gap(input int n);
        repeat (n) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic tick_period();
        gap(15);
        cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic add(input bit t, input bit v, input logic [7:0] d,
                       input bit et, input bit er, input bit eb);
        vec_t e;
        e.tick = t; e.valid = v; e.data = d;
        e.e_txd = et; e.e_ready = er; e.e_busy = eb;
        tbl.push_back(e);
    endtask

    initial begin
        int zeros;
        bit exp_bit;

        // 0x55 frame, then accept-and-tick in the same idle cycle with 0x12
        add(0, 1, 8'h55, 1, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1);
        add(1, 0, 8'h00, 1, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1);
        add(1, 0, 8'h00, 1, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1);
        add(1, 0, 8'h00, 1, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1);
        add(1, 0, 8'h00, 1, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1);
`ifdef UART_TX_PARITY_EN
        add(1, 0, 8'h00, 0, 1, 1);
`endif
        add(1, 0, 8'h00, 1, 1, 1);
        add(1, 0, 8'h00, 1, 1, 0);
        add(1, 1, 8'h12, 1, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1);

        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("reset_txd2", txd2, 1);
        check("reset_busy2", tx_busy2, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].tick) gap(15);
            cycle(tbl[i].tick, tbl[i].valid, tbl[i].data);
            check("tbl_txd", txd, tbl[i].e_txd);
            check("tbl_ready", tx_ready, tbl[i].e_ready);
            check("tbl_busy", tx_busy, tbl[i].e_busy);
        end
        repeat (11 + P) tick_period();

        // Back-to-back frames: second byte held during the first
        cycle(1'b0, 1'b1, 8'hA5);
        tick_period();
        gap(3);
        cycle(1'b0, 1'b1, 8'h3C);
        check("b2b_ready_low", tx_ready, 0);
        repeat (9 + P) tick_period();
        check("b2b_stop", txd, 1);
        tick_period();
        check("b2b_start2", txd, 0);
        check("b2b_ready_back", tx_ready, 1);
        repeat (11 + P) tick_period();
        check("b2b_idle", tx_busy, 0);

`ifdef UART_TX_PARITY_EN
        cycle(1'b0, 1'b1, 8'h07);
        repeat (10) tick_period();
        check("par_07", txd, 1);
        repeat (2) tick_period();
        cycle(1'b0, 1'b1, 8'h03);
        repeat (10) tick_period();
        check("par_03", txd, 0);
        repeat (2) tick_period();
`endif

        // Two stop bits on the second instance, next byte already held
        tx_valid2 = 1'b1;
        cycle(1'b0, 1'b0, 8'hFF);
        tx_valid2 = 1'b0;
        tick_period();
        check("s2_start", txd2, 0);
        gap(2);
        tx_valid2 = 1'b1;
        cycle(1'b0, 1'b0, 8'h5A);
        tx_valid2 = 1'b0;
        check("s2_ready_low", tx_ready2, 0);
        for (int k = 0; k < 10 + P; k++) begin
            tick_period();
            exp_bit = (P == 1 && k == 8) ? 1'b0 : 1'b1;
            check("s2_bit", txd2, exp_bit);
        end
        tick_period();
        check("s2_start2", txd2, 0);
        repeat (12 + P) tick_period();
        check("s2_idle", tx_busy2, 0);

        // Reset during data bit 3 of 0x00 with 0xF0 held
        cycle(1'b0, 1'b1, 8'h00);
        tick_period();
        cycle(1'b0, 1'b1, 8'hF0);
        repeat (4) tick_period();
        check("rst_bit3", txd, 0);
        gap(3);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_txd", txd, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        zeros = 0;
        for (int k = 0; k < 12; k++) begin
            tick_period();
            if (txd !== 1'b1) zeros++;
        end
        check("rst_nosend", zeros, 0);

        // tx_valid held with no ticks
        n_acc = 0;
        repeat (1000) cycle(1'b0, 1'b1, 8'h81);
        check("hold_acc", n_acc, 1);
        check("hold_txd", txd, 1);
        check("hold_busy", tx_busy, 1);
        gap(15);
        cycle(1'b1, 1'b0, 8'h00);
        check("hold_start", txd, 0);
        repeat (11 + P) tick_period();

        // Randomized traffic with occasional reset
        repeat (4000) begin
            cycle(bit'($urandom_range(7) == 0), bit'($urandom_range(2) == 0),
                  8'($urandom), bit'($urandom_range(599) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmitter that consumes the single-cycle baud tick from the bit-rate generator and turns byte-wide writes into asynchronous UART frames on `txd`. It sits between the host-side byte source and the pad. Every line transition happens only on a baud tick. A one-deep holding register lets back-to-back frames go out with no idle gap.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, legal values 5 to 8.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `baud_tick` in 1: one-`clk`-wide pulse, one per bit period, from the bit-rate generator.
- `tx_data` in DATA_BITS: byte to send, sampled when accepted.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding register is empty; a transfer occurs on `tx_valid && tx_ready`.
- `txd` out 1: serial line, idle high.
- `tx_busy` out 1: a frame is on the line, or the holding register is full.

## Operation
- Reset values: `txd`=1, `tx_ready`=1, `tx_busy`=0, state IDLE, holding register empty, bit counter 0.
- Handshake:
  - On `tx_valid && tx_ready`, `tx_data` is latched into the holding register.
  - `tx_ready` drops on the next cycle.
  - `tx_ready` is registered and equals "holding register empty".
- State machine; all transitions are qualified by `baud_tick`:
  - IDLE: on tick with holding register full, load the shifter, empty the holding register, go to START, `txd`=0.
  - START: on tick, go to DATA, `txd`=shifter bit 0.
  - DATA: on tick, shift right and increment the bit counter. After bit DATA_BITS-1, go to PARITY (if compiled in) or STOP. `txd`=1 in STOP.
  - PARITY: on tick, go to STOP, `txd`=1.
  - STOP: counts STOP_BITS ticks. On the final tick:
    - holding register full: reload the shifter and go straight to START, `txd`=0.
    - otherwise: go to IDLE.
- Data is sent LSB first.
- `txd` is a registered output; it is never driven combinationally.
- Frame length is 1 + DATA_BITS + P + STOP_BITS ticks, where P is 0 or 1.
- Bit counter is $clog2(DATA_BITS) wide and is cleared on each shifter load.
- `tx_busy` = (state != IDLE) or holding register full.

## Timing
- `txd` changes in the cycle after the qualifying `baud_tick`, so each bit lasts exactly one tick period.
- Start-bit latency after acceptance: up to one tick period plus 1 `clk`, because the frame aligns to the next tick.
- Accept and tick in the same cycle while IDLE with the holding register empty: the byte is latched; the frame starts on the following tick.
- Shifter reload from the holding register in the same cycle as `tx_valid`: no accept that cycle, because `tx_ready` is still 0. `tx_ready` rises one cycle later.
- No ticks arrive: the line holds its current level indefinitely, with no timeout.
- `tx_valid` deasserting before acceptance is allowed; nothing is latched.
- Reset mid-frame: the frame is abandoned, the holding register is discarded, and all outputs return to their reset values on the next cycle. A truncated frame on the line is acceptable.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds the PARITY state.
  - Parity bit = XOR of the payload bits (even parity), sent between the last data bit and the first stop bit.
  - Frame is one tick longer.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP. PARITY is present in the encoding even when unused.
  - `UART_IDLE_LEVEL` = 1.
  - default DATA_BITS and STOP_BITS constants shared with the future receiver.
- No sub-module. The shifter, counter and holding register are small enough to sit inline. The tick source stays an external instance.

## Test plan
- Send 0x55, one tick every 16 clk, no parity: after the first tick, `txd` reads 0,1,0,1,0,1,0,1,0,1,1 on successive ticks, then `tx_busy`=0.
- Send 0xA5 then 0x3C, with the second accepted during the first frame: the stop bit of frame 1 is immediately followed by the start bit of frame 2, with zero idle ticks; `tx_ready` is 0 only while the holding register is full.
- With `UART_TX_PARITY_EN`, send 0x07: the parity bit is 1 and the frame is 11 ticks. With 0x03, the parity bit is 0.
- `STOP_BITS`=2, send 0xFF: `txd` is high for 10 ticks after the start bit. A new byte already held starts only after both stop ticks.
- Assert `reset` during data bit 3 of 0x00: the next cycle `txd`=1, `tx_ready`=1, `tx_busy`=0, and the holding-register byte is not sent.
- Hold `tx_valid` with 0x81 and no ticks for 1000 clk: exactly one accept, `txd` stays 1, `tx_busy`=1. The start bit appears on the first tick that follows.
